// File: rtl/ex_stage_if.sv
// Data-SRAM request bus driven by the execute stage toward the data memory.
interface ex_stage_if;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;

  modport master (output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata);
  modport slave  (input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata);
endinterface

// File: rtl/ex_stage.sv
// MIPS execute stage: ID/EX register, operand select, one-hot ALU, data-SRAM
// request, HI/LO ownership and a 32-iteration restoring divider.
module ex_stage #(
  parameter int ID_TO_EX_WD  = 159,
  parameter int EX_TO_MEM_WD = 76,
  parameter int EX_TO_RF_WD  = 38,
  parameter int StallBus     = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [StallBus-1:0]     stall,
  input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
  output logic                    stallreq_for_ex,
  output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  output logic [EX_TO_RF_WD-1:0]  ex_to_rf_bus,
  ex_stage_if.master              data_sram
);

  localparam logic       Stop     = 1'b1;
  localparam logic [1:0] DIV_IDLE = 2'd0;
  localparam logic [1:0] DIV_RUN  = 2'd1;
  localparam logic [1:0] DIV_DONE = 2'd2;

  logic [ID_TO_EX_WD-1:0] id_to_ex_q, id_to_ex_d;

  always_comb begin
    id_to_ex_d = id_to_ex_q;
    if (stall[2] == Stop && stall[3] != Stop) id_to_ex_d = '0;
    else if (stall[2] != Stop)                id_to_ex_d = id_to_ex_bus;
  end

  logic [31:0] ex_pc, inst, rs_data, rt_data;
  logic [11:0] alu_op;
  logic [2:0]  sel_src1;
  logic [3:0]  sel_src2;
  logic        ram_en, rf_we, sel_rf_res;
  logic [3:0]  ram_wen;
  logic [4:0]  rf_waddr;

  assign {ex_pc, inst, alu_op, sel_src1, sel_src2, ram_en, ram_wen,
          rf_we, rf_waddr, sel_rf_res, rs_data, rt_data} = id_to_ex_q;

  logic [5:0] func;
  logic       special;
  logic       is_mult, is_multu, is_div, div_signed;
  logic       is_mfhi, is_mflo, is_mthi, is_mtlo;

  assign func       = inst[5:0];
  assign special    = (inst[31:26] == 6'b000000);
  assign is_mult    = special && (func == 6'b011000);
  assign is_multu   = special && (func == 6'b011001);
  assign is_div     = special && (func == 6'b011010 || func == 6'b011011);
  assign div_signed = ~func[0];
  assign is_mfhi    = special && (func == 6'b010000);
  assign is_mthi    = special && (func == 6'b010001);
  assign is_mflo    = special && (func == 6'b010010);
  assign is_mtlo    = special && (func == 6'b010011);

  logic [31:0] src1, src2, imm_sext, sra_res, alu_res, ex_result;
  logic        lt_s, lt_u;

  assign imm_sext = {{16{inst[15]}}, inst[15:0]};

  always_comb begin
    src1 = ({32{sel_src1[0]}} & rs_data)
         | ({32{sel_src1[1]}} & ex_pc)
         | ({32{sel_src1[2]}} & {27'b0, inst[10:6]});
    src2 = ({32{sel_src2[0]}} & rt_data)
         | ({32{sel_src2[1]}} & imm_sext)
         | ({32{sel_src2[2]}} & 32'd8)
         | ({32{sel_src2[3]}} & {16'b0, inst[15:0]});
    lt_s    = $signed(src1) < $signed(src2);
    lt_u    = src1 < src2;
    sra_res = $signed(src2) >>> src1[4:0];
    alu_res = ({32{alu_op[11]}} & (src1 + src2))
            | ({32{alu_op[10]}} & (src1 - src2))
            | ({32{alu_op[9]}}  & {31'b0, lt_s})
            | ({32{alu_op[8]}}  & {31'b0, lt_u})
            | ({32{alu_op[7]}}  & (src1 & src2))
            | ({32{alu_op[6]}}  & ~(src1 | src2))
            | ({32{alu_op[5]}}  & (src1 | src2))
            | ({32{alu_op[4]}}  & (src1 ^ src2))
            | ({32{alu_op[3]}}  & (src2 << src1[4:0]))
            | ({32{alu_op[2]}}  & (src2 >> src1[4:0]))
            | ({32{alu_op[1]}}  & sra_res)
            | ({32{alu_op[0]}}  & {src2[15:0], 16'b0});
  end

  logic [63:0] prod_s, prod_u;
  assign prod_s = $signed({{32{rs_data[31]}}, rs_data}) * $signed({{32{rt_data[31]}}, rt_data});
  assign prod_u = {32'b0, rs_data} * {32'b0, rt_data};

  logic [1:0]  div_state_q, div_state_d;
  logic [4:0]  div_cnt_q, div_cnt_d;
  logic [31:0] div_rem_q, div_rem_d, div_quot_q, div_quot_d, div_dvs_q, div_dvs_d;
  logic        div_qneg_q, div_qneg_d, div_rneg_q, div_rneg_d, div_zero_q, div_zero_d;
  logic [32:0] div_shift, div_sub;
  logic        div_ge;
  logic [31:0] div_q_fix, div_r_fix;

  always_comb begin
    div_state_d = div_state_q;
    div_cnt_d   = div_cnt_q;
    div_rem_d   = div_rem_q;
    div_quot_d  = div_quot_q;
    div_dvs_d   = div_dvs_q;
    div_qneg_d  = div_qneg_q;
    div_rneg_d  = div_rneg_q;
    div_zero_d  = div_zero_q;
    // quotient register doubles as the dividend shifter for the remainder
    div_shift   = {div_rem_q, div_quot_q[31]};
    div_sub     = div_shift - {1'b0, div_dvs_q};
    div_ge      = (div_shift >= {1'b0, div_dvs_q});
    case (div_state_q)
      DIV_IDLE: if (is_div) begin
        div_rem_d   = '0;
        div_quot_d  = (div_signed && rs_data[31]) ? -rs_data : rs_data;
        div_dvs_d   = (div_signed && rt_data[31]) ? -rt_data : rt_data;
        div_qneg_d  = div_signed && (rs_data[31] ^ rt_data[31]);
        div_rneg_d  = div_signed && rs_data[31];
        div_zero_d  = (rt_data == '0);
        div_cnt_d   = '0;
        div_state_d = DIV_RUN;
      end
      DIV_RUN: begin
        div_rem_d  = div_ge ? div_sub[31:0] : div_shift[31:0];
        div_quot_d = {div_quot_q[30:0], div_ge};
        div_cnt_d  = div_cnt_q + 5'd1;
        if (div_cnt_q == 5'd31) div_state_d = DIV_DONE;
      end
      DIV_DONE: if (stall[3] != Stop) div_state_d = DIV_IDLE;
      default:  div_state_d = DIV_IDLE;
    endcase
  end

  assign div_q_fix = div_zero_q ? '1 : (div_qneg_q ? -div_quot_q : div_quot_q);
  assign div_r_fix = div_rneg_q ? -div_rem_q : div_rem_q;

  logic [31:0] hi_q, hi_d, lo_q, lo_d;

  // HI/LO change only as the producer leaves EX; in DONE the div itself occupies EX
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (stall[3] != Stop) begin
      if (div_state_q == DIV_DONE) begin
        hi_d = div_r_fix;
        lo_d = div_q_fix;
      end else if (is_mult)  {hi_d, lo_d} = prod_s;
      else if (is_multu)     {hi_d, lo_d} = prod_u;
      else if (is_mthi)      hi_d = rs_data;
      else if (is_mtlo)      lo_d = rs_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_to_ex_q  <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      div_state_q <= DIV_IDLE;
      div_cnt_q   <= '0;
      div_rem_q   <= '0;
      div_quot_q  <= '0;
      div_dvs_q   <= '0;
      div_qneg_q  <= 1'b0;
      div_rneg_q  <= 1'b0;
      div_zero_q  <= 1'b0;
    end else begin
      id_to_ex_q  <= id_to_ex_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      div_state_q <= div_state_d;
      div_cnt_q   <= div_cnt_d;
      div_rem_q   <= div_rem_d;
      div_quot_q  <= div_quot_d;
      div_dvs_q   <= div_dvs_d;
      div_qneg_q  <= div_qneg_d;
      div_rneg_q  <= div_rneg_d;
      div_zero_q  <= div_zero_d;
    end
  end

  assign ex_result       = is_mfhi ? hi_q : (is_mflo ? lo_q : alu_res);
  assign stallreq_for_ex = (div_state_q == DIV_IDLE && is_div) || (div_state_q == DIV_RUN);
  assign ex_to_mem_bus   = {ex_pc, ram_en, ram_wen, sel_rf_res, rf_we, rf_waddr, ex_result};
  assign ex_to_rf_bus    = {rf_we, rf_waddr, ex_result};

  assign data_sram.data_sram_en    = ram_en;
  assign data_sram.data_sram_wen   = ram_wen;
  assign data_sram.data_sram_addr  = rs_data + imm_sext;
  assign data_sram.data_sram_wdata = rt_data;

  logic unused_bits;
  assign unused_bits = ^{inst[25:16], stall[5:4], stall[1:0], div_sub[32]};

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: table-driven ALU/memory vectors through a scoreboard
// queue, plus hand sequences for HI/LO, divider, stall and reset corners.
`timescale 1ns/1ps
module tb_ex_stage;
  localparam logic [11:0] OP_ADD = 12'h800, OP_SUB = 12'h400, OP_SLT = 12'h200, OP_SLTU = 12'h100;
  localparam logic [11:0] OP_AND = 12'h080, OP_NOR = 12'h040, OP_OR  = 12'h020, OP_XOR  = 12'h010;
  localparam logic [11:0] OP_SLL = 12'h008, OP_SRL = 12'h004, OP_SRA = 12'h002, OP_LUI  = 12'h001;
  localparam logic [2:0]  S1_RS = 3'b001, S1_PC = 3'b010, S1_SA = 3'b100;
  localparam logic [3:0]  S2_RT = 4'b0001, S2_SX = 4'b0010, S2_C8 = 4'b0100, S2_ZX = 4'b1000;

  typedef struct {
    logic [31:0] pc, inst;
    logic [11:0] alu;
    logic [2:0]  s1;
    logic [3:0]  s2;
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic        rf_we;
    logic [4:0]  waddr;
    logic        sel;
    logic [31:0] rs, rt, result;
  } vec_t;

  typedef struct {
    string       name;
    logic [75:0] mem;
    logic [37:0] rf;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr, wdata;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [5:0]   stall, manual_stall;
  logic         auto_stall;
  logic [158:0] id_bus;
  logic         stallreq;
  logic [75:0]  mem_bus;
  logic [37:0]  rf_bus;
  int           errors = 0;
  int           checks = 0;
  exp_t         exp_q[$];
  vec_t         vecs[18];
  vec_t         zero_v;

  ex_stage_if sram_if ();

  always #5 clk = ~clk;
  // Hazard-unit model: a busy divider freezes IF..EX
  always_comb stall = manual_stall | ((auto_stall && stallreq) ? 6'b001111 : 6'b000000);

  ex_stage dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .id_to_ex_bus   (id_bus),
    .stallreq_for_ex(stallreq),
    .ex_to_mem_bus  (mem_bus),
    .ex_to_rf_bus   (rf_bus),
    .data_sram      (sram_if)
  );

  function automatic logic [31:0] rtype(input logic [5:0] func, input logic [4:0] sa);
    return {6'b000000, 5'd1, 5'd2, 5'd3, sa, func};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [15:0] imm);
    return {op, 5'd1, 5'd2, imm};
  endfunction

  function automatic vec_t hilo(input logic [5:0] func, input logic [31:0] rs, input logic [31:0] rt,
                                input logic [31:0] res);
    vec_t v;
    v = '{32'hBFC0_0100, rtype(func, 5'd0), 12'h000, S1_RS, S2_RT, 1'b0, 4'h0, 1'b1, 5'd4, 1'b0, rs, rt, res};
    return v;
  endfunction

  function automatic logic [158:0] pack(input vec_t v);
    return {v.pc, v.inst, v.alu, v.s1, v.s2, v.ram_en, v.ram_wen, v.rf_we, v.waddr, v.sel, v.rs, v.rt};
  endfunction

  function automatic exp_t mk_exp(input string name, input vec_t v);
    exp_t e;
    e.name  = name;
    e.mem   = {v.pc, v.ram_en, v.ram_wen, v.sel, v.rf_we, v.waddr, v.result};
    e.rf    = {v.rf_we, v.waddr, v.result};
    e.en    = v.ram_en;
    e.wen   = v.ram_wen;
    e.addr  = v.rs + {{16{v.inst[15]}}, v.inst[15:0]};
    e.wdata = v.rt;
    return e;
  endfunction

  task automatic chk(input string name, input logic [75:0] act, input logic [75:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_front();
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: got empty queue expected an entry");
      return;
    end
    e = exp_q.pop_front();
    chk({e.name, ".mem_bus"}, mem_bus, e.mem);
    chk({e.name, ".rf_bus"}, 76'(rf_bus), 76'(e.rf));
    chk({e.name, ".sram_en"}, 76'(sram_if.data_sram_en), 76'(e.en));
    chk({e.name, ".sram_wen"}, 76'(sram_if.data_sram_wen), 76'(e.wen));
    chk({e.name, ".sram_addr"}, 76'(sram_if.data_sram_addr), 76'(e.addr));
    chk({e.name, ".sram_wdata"}, 76'(sram_if.data_sram_wdata), 76'(e.wdata));
  endtask

  task automatic tick_expect(input exp_t e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    check_front();
  endtask

  task automatic issue(input vec_t v, input string name);
    id_bus = pack(v);
    tick_expect(mk_exp(name, v));
  endtask

  task automatic run_div(input logic [5:0] func, input logic [31:0] rs, input logic [31:0] rt,
                         input string name);
    int cycles;
    id_bus     = pack(hilo(func, rs, rt, 32'h0));
    auto_stall = 1'b1;
    @(posedge clk);
    #1;
    cycles = 0;
    while (stallreq && cycles < 100) begin
      cycles++;
      @(posedge clk);
      #1;
    end
    chk({name, ".stall_cycles"}, 76'(cycles), 76'd33);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int stray;
    rst          = 1'b0;
    manual_stall = '0;
    auto_stall   = 1'b0;
    zero_v       = '{default: '0};
    id_bus       = 159'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
    #1;
    chk("reset.mem_bus", mem_bus, 76'h0);
    chk("reset.stallreq", 76'(stallreq), 76'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_held.mem_bus", mem_bus, 76'h0);
    chk("reset_held.rf_bus", 76'(rf_bus), 76'h0);
    chk("reset_held.sram", 76'({sram_if.data_sram_en, sram_if.data_sram_wen, sram_if.data_sram_addr,
                                sram_if.data_sram_wdata}), 76'h0);
    id_bus = '0;
    rst    = 1'b1;

    vecs[0]  = '{32'hBFC0_0000, itype(6'b001001, 16'h0001), OP_ADD, S1_RS, S2_SX, 1'b0, 4'h0, 1'b1, 5'd2, 1'b0, 32'h7FFF_FFFF, 32'h0, 32'h8000_0000};
    vecs[1]  = '{32'hBFC0_0004, rtype(6'b000011, 5'd4), OP_SRA, S1_SA, S2_RT, 1'b0, 4'h0, 1'b1, 5'd3, 1'b0, 32'h1234_5678, 32'h8000_0000, 32'hF800_0000};
    vecs[2]  = '{32'hBFC0_0008, rtype(6'b101010, 5'd0), OP_SLT, S1_RS, S2_RT, 1'b0, 4'h0, 1'b1, 5'd3, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'h1};
    vecs[3]  = '{32'hBFC0_000C, rtype(6'b101011, 5'd0), OP_SLTU, S1_RS, S2_RT, 1'b0, 4'h0, 1'b1, 5'd3, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'h0};
    vecs[4]  = '{32'hBFC0_0010, itype(6'b101011, 16'hFFFC), OP_ADD, S1_RS, S2_SX, 1'b1, 4'hF, 1'b0, 5'd2, 1'b0, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0000_0FFC};
    vecs[5]  = '{32'hBFC0_0014, itype(6'b100011, 16'h0010), OP_ADD, S1_RS, S2_SX, 1'b1, 4'h0, 1'b1, 5'd2, 1'b1, 32'h0000_2000, 32'h0000_5555, 32'h0000_2010};
    vecs[6]  = '{32'hBFC0_0018, itype(6'b001111, 16'h1234), OP_LUI, S1_RS, S2_ZX, 1'b0, 4'h0, 1'b1, 5'd2, 1'b0, 32'h9999_9999, 32'h0, 32'h1234_0000};
    vecs[7]  = '{32'hBFC0_001C, rtype(6'b100011, 5'd0), OP_SUB, S1_RS, S2_RT, 1'b0, 4'h0, 1'b1, 5'd3, 1'b0, 32'h5, 32'h7, 32'hFFFF_FFFE};
    vecs[8]  = '{32'hBFC0_0020, rtype(6'b100111, 5'd0), OP_NOR, S1_RS, S2_RT, 1'b0, 4'h0, 1'b1, 5'd3, 1'b0, 32'h0, 32'h0, 32'hFFFF_FFFF};
    vecs[9]  = '{32'hBFC0_0024, rtype(6'b000010, 5'd4), OP_SRL, S1_SA, S2_RT, 1'b0, 4'h0, 1'b1, 5'd3, 1'b0, 32'h0, 32'h8000_0000, 32'h0800_0000};
    vecs[10] = '{32'hBFC0_0028, 32'h0C00_0000, OP_ADD, S1_PC, S2_C8, 1'b0, 4'h0, 1'b1, 5'd31, 1'b0, 32'h0, 32'h0, 32'hBFC0_0030};
    vecs[11] = '{32'hBFC0_002C, itype(6'b000100, 16'h0003), 12'h000, S1_RS, S2_RT, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0, 32'h5, 32'h5, 32'h0};
    vecs[12] = '{32'hBFC0_0030, rtype(6'b100100, 5'd0), OP_AND, S1_RS, S2_RT, 1'b0, 4'h0, 1'b1, 5'd3, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000};
    vecs[13] = '{32'hBFC0_0034, rtype(6'b100110, 5'd0), OP_XOR, S1_RS, S2_RT, 1'b0, 4'h0, 1'b1, 5'd3, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0};
    vecs[14] = '{32'hBFC0_0038, rtype(6'b100101, 5'd0), OP_OR, S1_RS, S2_RT, 1'b0, 4'h0, 1'b1, 5'd3, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0};
    vecs[15] = '{32'hBFC0_003C, rtype(6'b000000, 5'd8), OP_SLL, S1_SA, S2_RT, 1'b0, 4'h0, 1'b1, 5'd3, 1'b0, 32'h0, 32'h0000_00FF, 32'h0000_FF00};
    vecs[16] = '{32'hBFC0_0040, rtype(6'b101011, 5'd0), OP_SLTU, S1_RS, S2_RT, 1'b0, 4'h0, 1'b1, 5'd3, 1'b0, 32'h1, 32'hFFFF_FFFF, 32'h1};
    vecs[17] = '{32'hBFC0_0044, rtype(6'b100001, 5'd0), OP_ADD, S1_RS, S2_RT, 1'b0, 4'h0, 1'b1, 5'd3, 1'b0, 32'hFFFF_FFFF, 32'h2, 32'h1};

    for (int i = 0; i < 18; i++) issue(vecs[i], $sformatf("vec%0d", i));

    issue(hilo(6'b011000, 32'hFFFF_FFFD, 32'h5, 32'h0), "mult");
    issue(hilo(6'b010000, 32'h0, 32'h0, 32'hFFFF_FFFF), "mfhi_mult");
    issue(hilo(6'b010010, 32'h0, 32'h0, 32'hFFFF_FFF1), "mflo_mult");
    issue(hilo(6'b011001, 32'hFFFF_FFFF, 32'h2, 32'h0), "multu");
    issue(hilo(6'b010000, 32'h0, 32'h0, 32'h0000_0001), "mfhi_multu");
    issue(hilo(6'b010010, 32'h0, 32'h0, 32'hFFFF_FFFE), "mflo_multu");
    issue(hilo(6'b010001, 32'hCAFE_0001, 32'h0, 32'h0), "mthi");
    issue(hilo(6'b010011, 32'h0BAD_0002, 32'h0, 32'h0), "mtlo");
    issue(hilo(6'b010000, 32'h0, 32'h0, 32'hCAFE_0001), "mfhi_mthi");
    issue(hilo(6'b010010, 32'h0, 32'h0, 32'h0BAD_0002), "mflo_mtlo");

    run_div(6'b011010, 32'hFFFF_FFF9, 32'h2, "div_m7_2");
    issue(hilo(6'b010010, 32'h0, 32'h0, 32'hFFFF_FFFD), "mflo_div");
    issue(hilo(6'b010000, 32'h0, 32'h0, 32'hFFFF_FFFF), "mfhi_div");

    run_div(6'b011011, 32'h1234_5678, 32'h0, "divu_zero");
    issue(hilo(6'b010010, 32'h0, 32'h0, 32'hFFFF_FFFF), "mflo_divz");
    issue(hilo(6'b010000, 32'h0, 32'h0, 32'h1234_5678), "mfhi_divz");

    run_div(6'b011011, 32'd100, 32'd7, "divu_hold");
    manual_stall = 6'b001111;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("done_hold%0d.stallreq", i), 76'(stallreq), 76'h0);
    end
    manual_stall = '0;
    issue(hilo(6'b010000, 32'h0, 32'h0, 32'd2), "mfhi_release");
    issue(hilo(6'b010001, 32'h0000_0055, 32'h0, 32'h0), "mthi_after");
    issue(hilo(6'b010000, 32'h0, 32'h0, 32'h0000_0055), "mfhi_once");
    issue(hilo(6'b010010, 32'h0, 32'h0, 32'd14), "mflo_once");

    issue(vecs[0], "pre_bubble");
    manual_stall = 6'b000100;
    id_bus       = pack(vecs[1]);
    tick_expect(mk_exp("bubble", zero_v));
    manual_stall = '0;
    issue(vecs[5], "pre_hold");
    manual_stall = 6'b001100;
    id_bus       = pack(vecs[6]);
    tick_expect(mk_exp("hold", vecs[5]));
    manual_stall = '0;
    tick_expect(mk_exp("after_hold", vecs[6]));

    id_bus = pack(hilo(6'b011010, 32'hFFFF_FFF9, 32'h2, 32'h0));
    auto_stall = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("mid_div.stallreq_before", 76'(stallreq), 76'h1);
    rst = 1'b0;
    #1;
    chk("mid_div.stallreq_async", 76'(stallreq), 76'h0);
    chk("mid_div.mem_bus_async", mem_bus, 76'h0);
    @(posedge clk);
    #1;
    id_bus = '0;
    rst    = 1'b1;
    stray  = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (stallreq) stray++;
    end
    chk("post_reset.stallreq_cycles", 76'(stray), 76'h0);
    issue(hilo(6'b010000, 32'h0, 32'h0, 32'h0), "mfhi_post_reset");
    issue(hilo(6'b010010, 32'h0, 32'h0, 32'h0), "mflo_post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
